// File: rtl/bcd_addsub_sequencer.sv
// Digit-serial BCD add/subtract controller: one nibble adder reused per clock,
// subtraction by nine's complement with end-around carry or a complement pass.
module bcd_addsub_sequencer #(
    parameter int DIGITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                op_i,
    input  logic [4*DIGITS-1:0] a_i,
    input  logic [4*DIGITS-1:0] b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [4*DIGITS-1:0] result_o,
    output logic                neg_o,
    output logic                ovf_o,
    output logic                invalid_o
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

    typedef enum logic [2:0] {IDLE, PASS1, PASS2, COMP, DONE} state_t;

    state_t                   state_q;
    logic [DIGITS-1:0][3:0]   aDig_q, bDig_q, work_q, result_q;
    logic                     op_q, carry_q, invalidNext_q;
    logic [IDXW-1:0]          idx_q;
    logic                     busy_q, done_q, neg_q, ovf_q, invalid_q;

    logic [DIGITS-1:0][3:0]   aIn, bIn, workNext, compWork;
    logic [3:0]               addendA, addendX, digitOut;
    logic [4:0]               rawSum;
    logic                     digitCarry, anyInvalid;

    assign aIn = a_i;
    assign bIn = b_i;

    // Shared decimal digit adder: PASS1 adds a and (b or 9-b), PASS2 ripples the carry.
    always_comb begin
        addendA = 4'd0;
        addendX = 4'd0;
        if (state_q == PASS2) begin
            addendA = work_q[idx_q];
        end else begin
            addendA = aDig_q[idx_q];
            addendX = op_q ? (4'd9 - bDig_q[idx_q]) : bDig_q[idx_q];
        end
        rawSum = {1'b0, addendA} + {1'b0, addendX} + {4'd0, carry_q};
        if (rawSum > 5'd9) begin
            digitOut   = 4'(rawSum - 5'd10);
            digitCarry = 1'b1;
        end else begin
            digitOut   = rawSum[3:0];
            digitCarry = 1'b0;
        end
        workNext         = work_q;
        workNext[idx_q]  = digitOut;
        compWork         = '0;
        anyInvalid       = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            compWork[i] = 4'd9 - work_q[i];
            if (aIn[i] > 4'd9 || bIn[i] > 4'd9) anyInvalid = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            aDig_q        <= '0;
            bDig_q        <= '0;
            work_q        <= '0;
            result_q      <= '0;
            op_q          <= 1'b0;
            carry_q       <= 1'b0;
            invalidNext_q <= 1'b0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            neg_q         <= 1'b0;
            ovf_q         <= 1'b0;
            invalid_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        aDig_q        <= aIn;
                        bDig_q        <= bIn;
                        op_q          <= op_i;
                        idx_q         <= '0;
                        carry_q       <= 1'b0;
                        invalidNext_q <= anyInvalid;
                        busy_q        <= 1'b1;
                        state_q       <= PASS1;
                    end
                end
                PASS1: begin
                    work_q  <= workNext;
                    carry_q <= digitCarry;
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST) begin
                        idx_q <= '0;
                        if (!op_q) begin
                            result_q  <= workNext;
                            ovf_q     <= digitCarry;
                            neg_q     <= 1'b0;
                            invalid_q <= invalidNext_q;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else if (digitCarry) begin
                            carry_q <= 1'b1;
                            state_q <= PASS2;
                        end else begin
                            state_q <= COMP;
                        end
                    end
                end
                PASS2: begin
                    work_q  <= workNext;
                    carry_q <= digitCarry;
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST) begin
                        idx_q     <= '0;
                        result_q  <= workNext;
                        ovf_q     <= 1'b0;
                        neg_q     <= 1'b0;
                        invalid_q <= invalidNext_q;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                COMP: begin
                    // A == B complements to all zeros, which must not read as negative.
                    work_q    <= compWork;
                    result_q  <= compWork;
                    neg_q     <= (compWork != '0);
                    ovf_q     <= 1'b0;
                    invalid_q <= invalidNext_q;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign neg_o     = neg_q;
    assign ovf_o     = ovf_q;
    assign invalid_o = invalid_q;

endmodule
